regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared RV32I constants and requester encodings
package regfile_wb_arbiter_pkg;

    localparam int RV_XLEN = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_idx_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rtl/regfile_wb_arbiter_rr_arb2.sv - two-way round-robin grant, one-hot output
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last,
    output logic [NUM_REQ-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_req[REQ_ALU] && i_req[REQ_LSU]) begin
            // On contention the requester that did not win last time goes first.
            if (i_last == REQ_ALU) begin
                o_gnt[REQ_LSU] = 1'b1;
            end else begin
                o_gnt[REQ_ALU] = 1'b1;
            end
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback arbiter with bypass match and conflict counter
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [4:0]        lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,
    output logic [4:0]        write_reg,
    output logic [XLEN-1:0]   write_data,
    output logic              write_enable,
    input  logic [4:0]        byp_addr_0,
    input  logic [4:0]        byp_addr_1,
    output logic              byp_hit_0,
    output logic              byp_hit_1,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_xfer;
    logic               w_sel_lsu;
    logic [4:0]         w_rd;
    logic [XLEN-1:0]    w_data;
    logic               w_conflict;

    req_idx_e           r_last;
    logic               r_we;
    logic [4:0]         r_reg;
    logic [XLEN-1:0]    r_data;
    logic [CNT_W-1:0]   r_cnt;

    // Masking requests with reset keeps both readies low while reset is held.
    assign w_req = {lsu_valid, alu_valid} & {NUM_REQ{reset}};

    rr_arb2 u_rr_arb2 (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    assign alu_ready  = w_gnt[REQ_ALU];
    assign lsu_ready  = w_gnt[REQ_LSU];
    assign w_xfer     = |w_gnt;
    assign w_sel_lsu  = w_gnt[REQ_LSU];
    assign w_rd       = w_sel_lsu ? lsu_rd   : alu_rd;
    assign w_data     = w_sel_lsu ? lsu_data : alu_data;
    assign w_conflict = alu_valid && lsu_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last <= REQ_ALU;
            r_we   <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            r_we <= w_xfer && (w_rd != 5'd0);
            if (w_xfer) begin
                r_last <= w_sel_lsu ? REQ_LSU : REQ_ALU;
            end
            // x0 writes are consumed but leave the visible write port untouched.
            if (w_xfer && (w_rd != 5'd0)) begin
                r_reg  <= w_rd;
                r_data <= w_data;
            end
            if (w_conflict && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign write_enable = r_we;
    assign write_reg    = r_reg;
    assign write_data   = r_data;
    assign conflict_cnt = r_cnt;

    assign byp_hit_0 = r_we && (byp_addr_0 == r_reg) && (byp_addr_0 != 5'd0);
    assign byp_hit_1 = r_we && (byp_addr_1 == r_reg) && (byp_addr_1 != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              alu_valid, lsu_valid;
    logic [4:0]        alu_rd, lsu_rd;
    logic [XLEN-1:0]   alu_data, lsu_data;
    logic              alu_ready, lsu_ready;
    logic [4:0]        write_reg;
    logic [XLEN-1:0]   write_data;
    logic              write_enable;
    logic [4:0]        byp_addr_0, byp_addr_1;
    logic              byp_hit_0, byp_hit_1;
    logic [CNT_W-1:0]  conflict_cnt;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .byp_addr_0   (byp_addr_0),
        .byp_addr_1   (byp_addr_1),
        .byp_hit_0    (byp_hit_0),
        .byp_hit_1    (byp_hit_1),
        .conflict_cnt (conflict_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: who won last, what the write port shows, how many conflicts seen.
    bit          m_last_lsu;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_hit(input logic [4:0] addr);
        return m_we && (addr == m_reg) && (addr != 5'd0);
    endfunction

    task automatic model_reset();
        m_last_lsu = 1'b0;
        m_we       = 1'b0;
        m_reg      = '0;
        m_data     = '0;
        m_cnt      = 0;
    endtask

    task automatic check_regs(input string ph);
        check({ph, "_we"},   32'(write_enable), 32'(m_we));
        check({ph, "_reg"},  32'(write_reg),    32'(m_reg));
        check({ph, "_data"}, write_data,        m_data);
        check({ph, "_cnt"},  32'(conflict_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] b0, input logic [4:0] b1);
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
        byp_addr_0 = b0; byp_addr_1 = b1;
    endtask

    // One clock with current inputs: check readies/bypass, advance model, check registers.
    task automatic step();
        bit          both, win_lsu, xfer;
        logic [4:0]  rd;
        logic [31:0] d;
        #1;
        both = alu_valid && lsu_valid;
        xfer = alu_valid || lsu_valid;
        if (both) win_lsu = !m_last_lsu;
        else      win_lsu = lsu_valid;
        check("alu_ready", 32'(alu_ready), 32'(xfer && !win_lsu));
        check("lsu_ready", 32'(lsu_ready), 32'(xfer && win_lsu));
        check("byp_hit_0", 32'(byp_hit_0), 32'(exp_hit(byp_addr_0)));
        check("byp_hit_1", 32'(byp_hit_1), 32'(exp_hit(byp_addr_1)));
        rd = win_lsu ? lsu_rd : alu_rd;
        d  = win_lsu ? lsu_data : alu_data;
        @(posedge clock);
        #1;
        if (xfer) m_last_lsu = win_lsu;
        m_we = xfer && (rd != 5'd0);
        if (m_we) begin
            m_reg  = rd;
            m_data = d;
        end
        if (both && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        check_regs("step");
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_regs("rst");
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        @(posedge clock);
        #1;
        check_regs("rst_edge");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd0, 5'd0);
        #2;
        model_reset();
        check_regs("por");
        check("por_alu_ready", 32'(alu_ready), 32'd0);
        check("por_lsu_ready", 32'(lsu_ready), 32'd0);
        @(posedge clock);
        #1;
        check_regs("por_edge");
        @(negedge clock);
        reset = 1'b1;

        // Single ALU request, usable on the first edge after release.
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        step();
        check("s1_we",   32'(write_enable), 32'd1);
        check("s1_reg",  32'(write_reg),    32'd5);
        check("s1_data", write_data,        32'h1234);

        // Bypass match against a pending write of x7.
        drive(1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
        #1;
        check("byp_7",   32'(byp_hit_0), 32'd1);
        check("byp_8",   32'(byp_hit_1), 32'd0);
        step();
        check("idle_we", 32'(write_enable), 32'd0);

        // LSU write to x0 is consumed but never strobes.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd7);
        #1;
        check("x0_lsu_ready", 32'(lsu_ready), 32'd1);
        step();
        check("x0_we",   32'(write_enable), 32'd0);
        check("x0_hold", 32'(write_reg),    32'd7);

        // Contention after reset alternates LSU, ALU, LSU, ALU.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd10, 32'h100 + i, 1'b1, 5'd11, 32'h200 + i, 5'd10, 5'd11);
            #1;
            check("ctn_lsu_ready", 32'(lsu_ready), 32'((i % 2) == 0));
            check("ctn_alu_ready", 32'(alu_ready), 32'((i % 2) == 1));
            step();
        end
        check("ctn_cnt4", 32'(conflict_cnt), 32'd4);

        // Sixteen more conflict cycles, 20 in total, must saturate.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'(i + 1), $urandom, 1'b1, 5'(i + 2), $urandom, 5'(i), 5'(i + 1));
            step();
        end
        check("sat_cnt", 32'(conflict_cnt), 32'(CNT_MAX));

        // Reset arrives mid-cycle while an ALU request is being accepted.
        drive(1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        #1;
        check("mid_alu_ready", 32'(alu_ready), 32'd1);
        #2;
        do_reset();
        check("mid_no_write", 32'(write_enable), 32'd0);
        drive(1'b1, 5'd12, 32'hC0DE, 1'b1, 5'd13, 32'hF00D, 5'd13, 5'd12);
        #1;
        check("mid_lsu_first", 32'(lsu_ready), 32'd1);
        step();
        check("mid_lsu_reg", 32'(write_reg), 32'd13);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if (i % 128 == 127) do_reset();
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 1) != 0) ? m_reg : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) != 0) ? m_reg : 5'($urandom_range(0, 31)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
